// File: rtl/serial_link_pkg.sv
// Shared types and the bring-up step table for the serial link sequencer.
package serial_link_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } cfg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } cfg_rsp_t;

  // Serial link config register offsets
  localparam logic [31:0] REG_CTRL         = 32'h0000_0000;
  localparam logic [31:0] REG_ISOLATED     = 32'h0000_0004;
  localparam logic [31:0] REG_ALLOC_TX_CFG = 32'h0000_0010;
  localparam logic [31:0] REG_ALLOC_RX_CFG = 32'h0000_0014;

  localparam logic [31:0] CTRL_RST_REL = 32'h0000_0300;
  localparam logic [31:0] CTRL_CLK_EN  = 32'h0000_0302;
  localparam logic [31:0] CTRL_ON      = 32'h0000_0303;
  localparam logic [31:0] CTRL_DEISO   = 32'h0000_0003;

  typedef enum logic [2:0] {
    STEP_RST_REL  = 3'd0,
    STEP_CLK_EN   = 3'd1,
    STEP_CTRL_ON  = 3'd2,
    STEP_ALLOC_TX = 3'd3,
    STEP_ALLOC_RX = 3'd4,
    STEP_SETTLE   = 3'd5,
    STEP_DEISO    = 3'd6,
    STEP_POLL     = 3'd7
  } step_e;

  typedef enum logic [1:0] {KIND_WRITE, KIND_SETTLE, KIND_READ} step_kind_e;

  typedef struct packed {
    logic [31:0] offset;
    logic [31:0] data;
    step_kind_e  kind;
  } step_t;

  function automatic step_t step_entry(input step_e s, input logic [31:0] alloc);
    step_t e;
    e.offset = REG_CTRL;
    e.data   = 32'h0;
    e.kind   = KIND_WRITE;
    case (s)
      STEP_RST_REL:  e.data = CTRL_RST_REL;
      STEP_CLK_EN:   e.data = CTRL_CLK_EN;
      STEP_CTRL_ON:  e.data = CTRL_ON;
      STEP_ALLOC_TX: begin e.offset = REG_ALLOC_TX_CFG; e.data = alloc; end
      STEP_ALLOC_RX: begin e.offset = REG_ALLOC_RX_CFG; e.data = alloc; end
      STEP_SETTLE:   e.kind = KIND_SETTLE;
      STEP_DEISO:    e.data = CTRL_DEISO;
      default:       begin e.offset = REG_ISOLATED; e.kind = KIND_READ; end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/serial_link_regbus_master.sv
// Single-outstanding regbus request holder: latches a request on i_start, holds it until ready.
module serial_link_regbus_master
  import serial_link_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_write,
  output cfg_req_t    o_req,
  input  cfg_rsp_t    i_rsp,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        r_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (r_valid) begin
      if (i_rsp.ready) r_valid <= 1'b0;
    end else if (i_start) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_write <= i_write;
    end
  end

  always_comb begin
    o_req.addr  = r_addr;
    o_req.write = r_write;
    o_req.wdata = r_wdata;
    o_req.wstrb = {4{r_write}};
    o_req.valid = r_valid;
  end

  assign o_ack   = r_valid & i_rsp.ready;
  assign o_rdata = i_rsp.rdata;
  assign o_err   = i_rsp.error;

endmodule

// File: rtl/serial_link_bringup_seq.sv
// Bring-up sequencer: walks the enabled links in ascending order through the step table over regbus.
module serial_link_bringup_seq
  import serial_link_pkg::*;
#(
  parameter int unsigned NumLinks     = 1,
  parameter logic [31:0] LinkStride   = 32'h1000,
  parameter logic [31:0] BaseAddr     = 32'h0,
  parameter logic [31:0] AllocCfg     = 32'h3,
  parameter int unsigned SettleCycles = 50,
  parameter int unsigned PollTimeout  = 1024,
  parameter int unsigned MaxRetries   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [NumLinks-1:0] link_en_i,
  output cfg_req_t            cfg_req_o,
  input  cfg_rsp_t            cfg_rsp_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [NumLinks-1:0] link_ready_o,
  output logic [NumLinks-1:0] link_err_o
);

  localparam int LW = (NumLinks > 1) ? $clog2(NumLinks) : 1;
  localparam int SW = $clog2(SettleCycles + 1);
  localparam int PW = $clog2(PollTimeout + 1);
  localparam int RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEL    = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_POLL   = 3'd4;
  localparam logic [2:0] S_RETRY  = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]          r_state;
  step_e               r_step;
  logic [LW-1:0]       r_link;
  logic [NumLinks-1:0] r_mask;
  logic [SW-1:0]       r_settle;
  logic [PW-1:0]       r_poll;
  logic [RW-1:0]       r_retry;
  logic [NumLinks-1:0] r_ready;
  logic [NumLinks-1:0] r_err;

  step_t       w_step;
  logic [31:0] w_addr;
  logic        w_start, w_ack, w_err;
  logic [31:0] w_rdata;
  logic        w_sel_hit;
  logic [LW-1:0] w_sel_idx;
  logic [PW-1:0] w_poll_nxt;

  assign w_step     = step_entry(r_step, AllocCfg);
  assign w_addr     = BaseAddr + 32'(r_link) * LinkStride + w_step.offset;
  assign w_start    = (r_state == S_WRITE) || (r_state == S_POLL);
  assign w_poll_nxt = r_poll + PW'(1);

  // Descending scan so the lowest pending link wins
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_idx = '0;
    for (int i = NumLinks - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_sel_hit = 1'b1;
        w_sel_idx = LW'(i);
      end
    end
  end

  serial_link_regbus_master u_mst (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_start (w_start),
    .i_addr  (w_addr),
    .i_wdata (w_step.data),
    .i_write (w_step.kind == KIND_WRITE),
    .o_req   (cfg_req_o),
    .i_rsp   (cfg_rsp_i),
    .o_ack   (w_ack),
    .o_rdata (w_rdata),
    .o_err   (w_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_step   <= STEP_RST_REL;
      r_link   <= '0;
      r_mask   <= '0;
      r_settle <= '0;
      r_poll   <= '0;
      r_retry  <= '0;
      r_ready  <= '0;
      r_err    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_mask  <= link_en_i;
          r_ready <= r_ready & ~link_en_i;
          r_err   <= r_err & ~link_en_i;
          r_state <= S_SEL;
        end
        S_SEL: if (w_sel_hit) begin
          r_link            <= w_sel_idx;
          r_mask[w_sel_idx] <= 1'b0;
          r_retry           <= '0;
          r_poll            <= '0;
          r_step            <= STEP_RST_REL;
          r_state           <= S_WRITE;
        end else begin
          r_state <= S_FIN;
        end
        S_WRITE: if (w_ack) begin
          if (w_err) r_state <= S_RETRY;
          else if (r_step == STEP_ALLOC_RX) begin
            r_step   <= STEP_SETTLE;
            r_settle <= '0;
            r_state  <= S_SETTLE;
          end else if (r_step == STEP_DEISO) begin
            r_step  <= STEP_POLL;
            r_state <= S_POLL;
          end else begin
            r_step <= step_e'(r_step + 3'd1);
          end
        end
        S_SETTLE: if (r_settle == SW'(SettleCycles - 1)) begin
          r_step  <= STEP_DEISO;
          r_state <= S_WRITE;
        end else begin
          r_settle <= r_settle + SW'(1);
        end
        S_POLL: if (w_ack) begin
          if (w_err) r_state <= S_RETRY;
          else if (w_rdata == '0) begin
            r_ready[r_link] <= 1'b1;
            r_state         <= S_SEL;
          end else begin
            r_poll <= w_poll_nxt;
            if (w_poll_nxt == PW'(PollTimeout)) r_state <= S_RETRY;
          end
        end
        S_RETRY: if (r_retry < RW'(MaxRetries)) begin
          r_retry <= r_retry + RW'(1);
          r_poll  <= '0;
          r_step  <= STEP_RST_REL;
          r_state <= S_WRITE;
        end else begin
          r_err[r_link] <= 1'b1;
          r_state       <= S_SEL;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_FIN);
  assign link_ready_o = r_ready;
  assign link_err_o   = r_err;

endmodule
